// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline defines: stall bus width, per-stage NOP payloads, reset level
// and the occupancy-coded state encoding of the skid stage.
package pipe_stage_skid_pkg;

  localparam int          StallBus   = 6;
  localparam logic        RstEnable  = 1'b1;
  localparam logic [4:0]  NOPRegAddr = 5'b00000;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [7:0]  EX_NOP     = 8'h00;

  // {wd, wreg, wdata, mem_addr, aluop} bubble for the EX->MEM boundary
  localparam int              ExMemW     = 5 + 1 + 32 + 32 + 8;
  localparam logic [ExMemW-1:0] EX_MEM_NOP = {NOPRegAddr, 1'b0, ZeroWord, ZeroWord, EX_NOP};

  // {wd, wreg, wdata} bubble for the MEM->WB boundary
  localparam int                MemWbW     = 5 + 1 + 32;
  localparam logic [MemWbW-1:0] MEM_WB_NOP = {NOPRegAddr, 1'b0, ZeroWord};

  // Encoding equals the number of held entries so occupancy is the state itself
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) valid/ready pipeline latch with registered in_ready,
// legacy stall bit, global freeze, flush-to-bubble and saturating back-pressure count.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int            DW        = 32,
  parameter logic [DW-1:0] NOP_VAL   = {DW{1'b0}},
  parameter int            STALL_W   = StallBus,
  parameter int            STALL_BIT = 4,
  parameter int            CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   bp_cycles
);

  state_t            state_q, state_d;
  logic [DW-1:0]     main_q, main_d;
  logic [DW-1:0]     skid_q, skid_d;
  logic [CNT_W-1:0]  bp_q;
  logic              eff_ready, acc, pop, bp_hit;
  logic              unused_stall;

  assign unused_stall = ^stall;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign out_data  = main_q;
  assign bp_cycles = bp_q;

  assign eff_ready = out_ready & ~stall[STALL_BIT];
  assign acc       = rdy & in_valid & in_ready;
  assign pop       = rdy & out_valid & eff_ready;
  assign bp_hit    = rdy & out_valid & ~eff_ready & ~flush;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (rdy) begin
      if (flush) begin
        state_d = EMPTY;
        main_d  = NOP_VAL;
        skid_d  = NOP_VAL;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (acc) begin
              state_d = HALF;
              main_d  = in_data;
            end
          end
          HALF: begin
            if (acc && pop) begin
              main_d = in_data;
            end else if (acc) begin
              state_d = FULL;
              skid_d  = in_data;
            end else if (pop) begin
              state_d = EMPTY;
              main_d  = NOP_VAL;
            end
          end
          FULL: begin
            // in_ready is low here, so only the drain side can move
            if (pop) begin
              state_d = HALF;
              main_d  = skid_q;
              skid_d  = NOP_VAL;
            end
          end
          default: begin
            state_d = EMPTY;
            main_d  = NOP_VAL;
            skid_d  = NOP_VAL;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      bp_q <= '0;
    end else if (bp_hit && !(&bp_q)) begin
      bp_q <= bp_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_skid;

  localparam int DW    = 32;
  localparam int CNT_W = 4;
  localparam int BPMAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst, rdy, flush, in_valid, out_ready;
  logic [5:0]       stall;
  logic [DW-1:0]    in_data;
  logic             in_ready, out_valid;
  logic [DW-1:0]    out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] bp_cycles;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] mq[$];
  int            mbp;

  pipe_stage_skid #(
    .DW(DW), .NOP_VAL({DW{1'b0}}), .STALL_W(6), .STALL_BIT(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .bp_cycles(bp_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a FIFO of at most two words plus a saturating counter
  always @(posedge clk) begin
    bit er, ov, ir;
    if (rst) begin
      mq.delete();
      mbp = 0;
    end else if (rdy) begin
      if (flush) begin
        mq.delete();
      end else begin
        er = out_ready && !stall[4];
        ov = mq.size() > 0;
        ir = mq.size() < 2;
        if (ov && !er && mbp < BPMAX) mbp = mbp + 1;
        if (ov && er) void'(mq.pop_front());
        if (in_valid && ir) mq.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int            n;
      logic [DW-1:0] ed;
      n  = mq.size();
      ed = (n > 0) ? mq[0] : '0;
      total += 5;
      if (out_valid !== (n > 0)) begin
        bad++; $display("FAIL model out_valid: got %b want %b (t=%0t)", out_valid, n > 0, $time);
      end
      if (in_ready !== (n < 2)) begin
        bad++; $display("FAIL model in_ready: got %b want %b (t=%0t)", in_ready, n < 2, $time);
      end
      if (occupancy !== 2'(n)) begin
        bad++; $display("FAIL model occupancy: got %0d want %0d (t=%0t)", occupancy, n, $time);
      end
      if (out_data !== ed) begin
        bad++; $display("FAIL model out_data: got %h want %h (t=%0t)", out_data, ed, $time);
      end
      if (bp_cycles !== CNT_W'(mbp)) begin
        bad++; $display("FAIL model bp_cycles: got %0d want %0d (t=%0t)", bp_cycles, mbp, $time);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic rd, input logic fl, input logic iv,
                     input logic [DW-1:0] d, input logic ordy, input logic [5:0] st);
    rst = r; rdy = rd; flush = fl; in_valid = iv; in_data = d;
    out_ready = ordy; stall = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; stall = '0;

    // Reset then idle
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst occupancy", occupancy, 0);
    chk("rst bp_cycles", bp_cycles, 0);

    // Streaming 1..8 at full throughput
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, 1, DW'(i), 1, 0);
      chk("stream out_data", out_data, i);
      chk("stream occupancy", occupancy, 1);
    end
    cyc(0, 1, 0, 0, 0, 1, 0);
    chk("stream drained", occupancy, 0);

    // Back-pressure into the skid entry
    cyc(0, 1, 0, 1, 32'hA, 0, 0);
    cyc(0, 1, 0, 1, 32'hB, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("skid occupancy", occupancy, 2);
    chk("skid in_ready", in_ready, 0);
    chk("skid bp_cycles", bp_cycles, 2);
    chk("skid head", out_data, 32'hA);
    cyc(0, 1, 0, 0, 0, 1, 0);
    chk("skid second", out_data, 32'hB);
    chk("skid occ after pop", occupancy, 1);
    cyc(0, 1, 0, 0, 0, 1, 0);
    chk("skid empty", occupancy, 0);
    chk("skid bp held", bp_cycles, 2);

    // Legacy stall bit freezes the output side
    cyc(0, 1, 0, 1, 32'hC, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 1, 6'b010000);
    chk("stall frozen data", out_data, 32'hC);
    chk("stall bp", bp_cycles, 5);
    cyc(0, 1, 0, 0, 0, 1, 6'b101111);
    chk("other stall bits ignored", occupancy, 0);
    chk("other stall bits bp", bp_cycles, 5);

    // Flush while FULL, with a word offered the same cycle
    cyc(0, 1, 0, 1, 32'hD, 0, 0);
    cyc(0, 1, 0, 1, 32'hE, 0, 0);
    chk("pre-flush occ", occupancy, 2);
    cyc(0, 1, 1, 1, 32'hF, 0, 0);
    chk("flush occ", occupancy, 0);
    chk("flush data", out_data, 0);
    chk("flush bp", bp_cycles, 6);
    cyc(0, 1, 0, 0, 0, 1, 0);
    chk("flush dropped", occupancy, 0);

    // Global freeze with toggling inputs, then reset while frozen
    cyc(0, 1, 0, 1, 32'h77, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 6'($urandom));
    chk("freeze occ", occupancy, 1);
    chk("freeze data", out_data, 32'h77);
    chk("freeze bp", bp_cycles, 6);
    cyc(1, 0, 0, 1, 32'h99, 1, 0);
    chk("rst during freeze occ", occupancy, 0);
    chk("rst during freeze bp", bp_cycles, 0);

    // Counter saturation
    cyc(0, 1, 0, 1, 32'h55, 0, 0);
    for (int i = 0; i < BPMAX + 5; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    chk("bp saturates", bp_cycles, BPMAX);
    chk("sat head", out_data, 32'h55);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 85),
          ($urandom_range(0, 99) < 4), 1'($urandom), $urandom,
          ($urandom_range(0, 99) < 60), ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0);
    end
    cyc(0, 1, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    chk("final drained", occupancy, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
